// File: rtl/serial_parity_rx_if.sv
// Handshake bundle between a serial bit source / word consumer and the
// serial_parity_rx front end.
interface serial_parity_rx_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  bitin;
  logic                  bitvalid;
  logic                  outack;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  parityout;
  logic                  outvalid;
  logic                  parityerr;
  logic                  frameerr;
  logic                  overrun;
  logic                  busy;

  // Source of the bit stream and consumer of assembled words.
  modport master (
    output bitin, bitvalid, outack,
    input  dataout, parityout, outvalid, parityerr, frameerr, overrun, busy
  );

  // The receiver itself.
  modport slave (
    input  bitin, bitvalid, outack,
    output dataout, parityout, outvalid, parityerr, frameerr, overrun, busy
  );
endinterface

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start bit, DATA_WIDTH data bits LSB first, parity
// bit, stop bit. Assembles the word, checks parity in-line and holds the
// result behind a valid/ack handshake.
module serial_parity_rx #(
  parameter int DATA_WIDTH = 32,
  parameter bit ODD        = 1'b0
) (
  input logic               clk,
  input logic               rst,
  serial_parity_rx_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  run_par;
  logic                  par_bit;
  logic                  frame_done;
  logic                  frame_bad;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  parity_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  overrun_q;

  // State register; transitions are decided in the next-state process.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus frame completion / framing-error strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_next = state;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    if (bus.bitvalid) begin
      unique case (state)
        IDLE:   if (!bus.bitin) state_next = DATA;
        DATA:   if (cnt == LAST_BIT) state_next = PARITY;
        PARITY: state_next = STOP;
        STOP: begin
          state_next = IDLE;
          frame_done = bus.bitin;
          frame_bad  = !bus.bitin;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Bit assembly: shift register, running parity and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      shreg   <= '0;
      run_par <= 1'b0;
      par_bit <= 1'b0;
    end else if (bus.bitvalid) begin
      unique case (state)
        IDLE: begin
          if (!bus.bitin) begin
            cnt     <= '0;
            run_par <= 1'b0;
          end
        end
        DATA: begin
          // Shifting in from the top leaves the first data bit in bit 0
          // once DATA_WIDTH bits have arrived.
          shreg   <= {bus.bitin, shreg[DATA_WIDTH-1:1]};
          run_par <= run_par ^ bus.bitin;
          cnt     <= cnt + CW'(1);
        end
        PARITY: par_bit <= bus.bitin;
        default: ;
      endcase
    end
  end

  // Output holding register, handshake, framing-error pulse and overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      parity_q  <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ferr_q <= frame_bad;
      if (frame_done) begin
        if (!valid_q || bus.outack) begin
          data_q   <= shreg;
          parity_q <= par_bit;
          perr_q   <= par_bit ^ run_par ^ ODD;
          valid_q  <= 1'b1;
        end else begin
          // Consumer still holds the previous word: drop the new one.
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.outack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.dataout   = data_q;
  assign bus.parityout = parity_q;
  assign bus.outvalid  = valid_q;
  assign bus.parityerr = perr_q;
  assign bus.frameerr  = ferr_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state != IDLE);

endmodule
